// File: rtl/multi_freq_counter.sv
// multi_freq_counter: per-channel edge counter over a programmable gate window, results read out by valid/ready
// Ports:
//   clk, rst_n        clock and synchronous active-low reset
//   signal_in         measured signals, one bit per channel
//   period_in         new gate period in cycles, captured by load_period (0 ignored)
//   edge_mode         0 = rising edges, 1 = both edges (latched at window start)
//   result_valid/ready  output handshake, one beat per channel, chan 0 first
//   result_chan/count/sat/overrun  presented beat: channel, count, saturated, windows dropped before batch
//   dbg_state, dbg_window  output FSM state and live window counter
// Macro FREQ_CNT_SYNC_EN adds a 2-flop synchroniser on every signal_in bit.
module multi_freq_counter #(
    parameter int CHANNELS   = 4,
    parameter int COUNT_W    = 16,
    parameter int PERIOD_W   = 12,
    parameter int PERIOD_RST = 1000,
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] signal_in,
    input  logic [PERIOD_W-1:0] period_in,
    input  logic                load_period,
    input  logic                edge_mode,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CW-1:0]       result_chan,
    output logic [COUNT_W-1:0]  result_count,
    output logic                result_sat,
    output logic                result_overrun,
    output logic [1:0]          dbg_state,
    output logic [PERIOD_W-1:0] dbg_window
);
    localparam logic [1:0] IDLE = 2'b00, SEND = 2'b01;
    logic [CHANNELS-1:0] sig, prev, ev, sat, sat_nx, sat_sh;
    logic [CHANNELS-1:0][COUNT_W-1:0] live, live_nx, shadow;
    logic [PERIOD_W-1:0] win, per, pend;
    logic pend_v, mode, ovr, ovr_out, win_end, load_ok, hs, last, take;
    logic [1:0] state;
    logic [CW-1:0] chan;
`ifdef FREQ_CNT_SYNC_EN
    logic [CHANNELS-1:0] s1, s2;
    always_ff @(posedge clk)
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= signal_in;
            s2 <= s1;
        end
    assign sig = s2;
`else
    assign sig = signal_in;
`endif
    assign ev      = mode ? (sig ^ prev) : (sig & ~prev);
    assign win_end = win == per - 1'b1;
    assign load_ok = load_period && period_in != '0;
    assign hs      = state == SEND && result_ready;
    assign last    = chan == CW'(CHANNELS - 1);
    assign take    = state == IDLE && win_end;
    // Saturating increment; sat records an edge that arrived with the counter already full.
    always_comb begin
        live_nx = live;
        sat_nx  = sat;
        for (int i = 0; i < CHANNELS; i++) begin
            live_nx[i] = (ev[i] && live[i] != '1) ? live[i] + 1'b1 : live[i];
            sat_nx[i]  = sat[i] | (ev[i] & (live[i] == '1));
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= '0;
            win     <= '0;
            per     <= PERIOD_W'(PERIOD_RST);
            pend    <= '0;
            pend_v  <= 1'b0;
            mode    <= 1'b0;
            live    <= '0;
            sat     <= '0;
            shadow  <= '0;
            sat_sh  <= '0;
            ovr     <= 1'b0;
            ovr_out <= 1'b0;
            state   <= IDLE;
            chan    <= '0;
        end else begin
            prev <= sig;
            win  <= win_end ? '0 : win + 1'b1;
            // Period and mode change only across the window boundary; a strobe in the end cycle still wins.
            if (win_end) begin
                per    <= load_ok ? period_in : pend_v ? pend : per;
                pend_v <= 1'b0;
                mode   <= edge_mode;
                live   <= '0;
                sat    <= '0;
            end else begin
                if (load_ok) begin
                    pend   <= period_in;
                    pend_v <= 1'b1;
                end
                live <= live_nx;
                sat  <= sat_nx;
            end
            // Edges in the end cycle are folded in via live_nx; windows ending outside IDLE are dropped.
            if (take) begin
                shadow  <= live_nx;
                sat_sh  <= sat_nx;
                ovr_out <= ovr;
                ovr     <= 1'b0;
            end else if (win_end) begin
                ovr <= 1'b1;
            end
            if (take) begin
                state <= SEND;
                chan  <= '0;
            end else if (state == SEND) begin
                if (hs) chan <= last ? '0 : chan + 1'b1;
                if (hs && last) state <= IDLE;
            end else begin
                state <= IDLE;
            end
        end
    end
    assign result_valid   = state == SEND;
    assign result_chan    = chan;
    assign result_count   = shadow[chan];
    assign result_sat     = sat_sh[chan];
    assign result_overrun = ovr_out;
    assign dbg_state      = state;
    assign dbg_window     = win;
endmodule

// File: tb/tb_multi_freq_counter.sv
// tb_multi_freq_counter: directed bench for multi_freq_counter (4 channels, 8-bit counts, sync off)
module tb_multi_freq_counter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  signal_in;
    logic [11:0] period_in = '0;
    logic        load_period = 1'b0;
    logic        edge_mode = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b1;
    logic [1:0]  result_chan;
    logic [7:0]  result_count;
    logic        result_sat;
    logic        result_overrun;
    logic [1:0]  dbg_state;
    logic [11:0] dbg_window;
    int n_cmp = 0, n_err = 0, cyc = 0;
    logic en0 = 1'b0, en1 = 1'b0;
    int b_t;
    int b_chan [4], b_cnt [4], b_sat [4], b_ovr [4];
    multi_freq_counter #(.CHANNELS(4), .COUNT_W(8), .PERIOD_W(12), .PERIOD_RST(1000)) dut (
        .clk(clk), .rst_n(rst_n), .signal_in(signal_in), .period_in(period_in),
        .load_period(load_period), .edge_mode(edge_mode), .result_valid(result_valid),
        .result_ready(result_ready), .result_chan(result_chan), .result_count(result_count),
        .result_sat(result_sat), .result_overrun(result_overrun), .dbg_state(dbg_state),
        .dbg_window(dbg_window)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // ch0 toggles every 5 clocks (10 rising edges per 100 cycles), ch1 every clock.
    initial begin
        int c0 = 0;
        signal_in = '0;
        forever begin
            @(posedge clk);
            #1;
            if (en0) begin
                c0++;
                if (c0 == 5) begin
                    c0 = 0;
                    signal_in[0] = ~signal_in[0];
                end
            end
            if (en1) signal_in[1] = ~signal_in[1];
        end
    end
    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic next_sample;
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid;
        int n = 0;
        while (!result_valid && n < 3000) begin
            next_sample;
            n++;
        end
        if (!result_valid) check("valid_timeout", 0, 1);
    endtask
    task automatic pulse_load(input logic [11:0] p);
        period_in = p;
        load_period = 1'b1;
        next_sample;
        load_period = 1'b0;
    endtask
    task automatic get_batch;
        for (int i = 0; i < 4; i++) begin
            wait_valid;
            if (i == 0) b_t = cyc;
            b_chan[i] = result_chan;
            b_cnt[i]  = result_count;
            b_sat[i]  = result_sat;
            b_ovr[i]  = result_overrun;
            next_sample;
        end
        check("valid_drop", result_valid, 0);
    endtask
    task automatic check_batch(input string tag, input int c0, input int ov);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_chan%0d", tag, i), b_chan[i], i);
            check($sformatf("%s_cnt%0d", tag, i), b_cnt[i], i == 0 ? c0 : 0);
            check($sformatf("%s_sat%0d", tag, i), b_sat[i], 0);
            check($sformatf("%s_ovr%0d", tag, i), b_ovr[i], ov);
        end
    endtask
    initial begin
        int hc, hcnt, hsat, unst, t0, t1;
        repeat (3) next_sample;
        check("rst_valid", result_valid, 0);
        check("rst_state", dbg_state, 0);
        check("rst_window", dbg_window, 0);
        check("rst_chan", result_chan, 0);
        check("rst_ovr", result_overrun, 0);
        rst_n = 1'b1;
        repeat (5) next_sample;
        check("win_count", dbg_window, 5);
        en0 = 1'b1;
        pulse_load(12'd100);
        get_batch;
        get_batch;
        check_batch("rise", 10, 0);
        edge_mode = 1'b1;
        get_batch;
        check_batch("mode_cur", 10, 0);
        get_batch;
        check("mode_both_cnt", b_cnt[0], 20);
        edge_mode = 1'b0;
        en1 = 1'b1;
        pulse_load(12'd1000);
        get_batch;
        get_batch;
        check("sat_ch0_cnt", b_cnt[0], 100);
        check("sat_ch0_flag", b_sat[0], 0);
        check("sat_ch1_cnt", b_cnt[1], 255);
        check("sat_ch1_flag", b_sat[1], 1);
        check("sat_ch2_flag", b_sat[2], 0);
        check("sat_ch3_flag", b_sat[3], 0);
        en1 = 1'b0;
        pulse_load(12'd100);
        get_batch;
        result_ready = 1'b0;
        wait_valid;
        hc = result_chan;
        hcnt = result_count;
        hsat = result_sat;
        check("held_chan", hc, 0);
        check("held_cnt", hcnt, 10);
        unst = 0;
        for (int i = 0; i < 250; i++) begin
            next_sample;
            if (!result_valid || result_chan != hc || result_count != hcnt || result_sat != hsat) unst++;
        end
        check("hold_stable", unst, 0);
        result_ready = 1'b1;
        get_batch;
        check_batch("held", 10, 0);
        get_batch;
        check_batch("ovr_set", 10, 1);
        get_batch;
        check_batch("ovr_clr", 10, 0);
        t0 = b_t;
        pulse_load(12'd0);
        get_batch;
        check("win_len_p0", b_t - t0, 100);
        t1 = b_t;
        pulse_load(12'd50);
        get_batch;
        check("win_len_cur", b_t - t1, 100);
        t1 = b_t;
        get_batch;
        check("win_len_50", b_t - t1, 50);
        check("cnt_50", b_cnt[0], 5);
        result_ready = 1'b0;
        wait_valid;
        rst_n = 1'b0;
        next_sample;
        check("rst_send_valid", result_valid, 0);
        check("rst_send_state", dbg_state, 0);
        check("rst_send_window", dbg_window, 0);
        check("rst_send_chan", result_chan, 0);
        rst_n = 1'b1;
        next_sample;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
